// File: rtl/sp_ram_fifo_pkg.sv
// Shared definitions for the single-port-RAM FIFO controller: grant encoding and width helpers.
package sp_ram_fifo_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_WR   = 2'b01,
    GNT_RD   = 2'b10
  } grant_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sp_ram_fifo_ctrl_if.sv
// Producer, consumer and RAM-side signals of sp_ram_fifo_ctrl.
// Almost flags exist only when SP_RAM_FIFO_ALMOST_FLAGS_EN is defined.
interface sp_ram_fifo_ctrl_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 256
);
  import sp_ram_fifo_pkg::*;

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic             i_Wr_DV;
  logic [WIDTH-1:0] i_Wr_Data;
  logic             o_Wr_Ready;
  logic             i_Rd_En;
  logic             o_Rd_Ready;
  logic             o_Rd_DV;
  logic [WIDTH-1:0] o_Rd_Data;
  logic             o_Full;
  logic             o_Empty;
  logic [CW-1:0]    o_Count;
  logic [PW-1:0]    o_Ram_Addr;
  logic             o_Ram_Wr_DV;
  logic [WIDTH-1:0] o_Ram_Wr_Data;
  logic             o_Ram_Rd_En;
  logic             i_Ram_Rd_DV;
  logic [WIDTH-1:0] i_Ram_Rd_Data;
`ifdef SP_RAM_FIFO_ALMOST_FLAGS_EN
  logic             o_Almost_Full;
  logic             o_Almost_Empty;
`endif

  modport master (
    input  i_Wr_DV, i_Wr_Data, i_Rd_En, i_Ram_Rd_DV, i_Ram_Rd_Data,
    output o_Wr_Ready, o_Rd_Ready, o_Rd_DV, o_Rd_Data, o_Full, o_Empty, o_Count,
    output o_Ram_Addr, o_Ram_Wr_DV, o_Ram_Wr_Data, o_Ram_Rd_En
`ifdef SP_RAM_FIFO_ALMOST_FLAGS_EN
    , output o_Almost_Full, o_Almost_Empty
`endif
  );

  modport slave (
    output i_Wr_DV, i_Wr_Data, i_Rd_En, i_Ram_Rd_DV, i_Ram_Rd_Data,
    input  o_Wr_Ready, o_Rd_Ready, o_Rd_DV, o_Rd_Data, o_Full, o_Empty, o_Count,
    input  o_Ram_Addr, o_Ram_Wr_DV, o_Ram_Wr_Data, o_Ram_Rd_En
`ifdef SP_RAM_FIFO_ALMOST_FLAGS_EN
    , input o_Almost_Full, o_Almost_Empty
`endif
  );

endinterface

// File: rtl/sp_ram_fifo_arb.sv
// Two-requester round-robin arbiter for the shared RAM port; remembers the last contended winner.
module sp_ram_fifo_arb
  import sp_ram_fifo_pkg::*;
(
  input  logic   clk,
  input  logic   rst_l,
  input  logic   wr_elig,
  input  logic   rd_elig,
  output grant_t grant
);

  typedef enum logic {LAST_WR, LAST_RD} last_t;

  last_t last_q, last_d;

  always_ff @(posedge clk) begin
    if (!rst_l) last_q <= LAST_WR;
    else        last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    grant  = GNT_NONE;
    if (!rst_l) begin
      grant = GNT_NONE;
    end else if (wr_elig && rd_elig) begin
      if (last_q == LAST_WR) begin
        grant  = GNT_RD;
        last_d = LAST_RD;
      end else begin
        grant  = GNT_WR;
        last_d = LAST_WR;
      end
    end else if (wr_elig) begin
      grant = GNT_WR;
    end else if (rd_elig) begin
      grant = GNT_RD;
    end
  end

endmodule

// File: rtl/sp_ram_fifo_ctrl.sv
// Synchronous FIFO built on a single-port RAM: one access per cycle, push/pop arbitrated round-robin.
// Optional almost-full/almost-empty flags under SP_RAM_FIFO_ALMOST_FLAGS_EN.
module sp_ram_fifo_ctrl
  import sp_ram_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 256
`ifdef SP_RAM_FIFO_ALMOST_FLAGS_EN
  ,
  parameter int unsigned ALMOST_FULL_LEVEL  = DEPTH - 2,
  parameter int unsigned ALMOST_EMPTY_LEVEL = 2
`endif
) (
  input logic               i_Clk,
  input logic               i_Rst_L,
  sp_ram_fifo_ctrl_if.master bus
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_nxt;
  logic             rd_pend, full, empty, wr_gnt, rd_gnt;
  logic [WIDTH-1:0] push_word;
  grant_t           grant;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  sp_ram_fifo_arb u_arb (
    .clk     (i_Clk),
    .rst_l   (i_Rst_L),
    .wr_elig (bus.i_Wr_DV && !full),
    .rd_elig (bus.i_Rd_En && !empty),
    .grant   (grant)
  );

  assign wr_gnt = (grant == GNT_WR);
  assign rd_gnt = (grant == GNT_RD);

  always_comb begin
    count_nxt = count;
    if (wr_gnt)      count_nxt = count + CW'(1);
    else if (rd_gnt) count_nxt = count - CW'(1);
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_pend <= 1'b0;
    end else begin
      if (wr_gnt) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_gnt) rd_ptr <= ptr_inc(rd_ptr);
      count   <= count_nxt;
      rd_pend <= rd_gnt;
    end
  end

  assign push_word          = bus.i_Wr_Data;
  assign bus.o_Wr_Ready     = wr_gnt;
  assign bus.o_Rd_Ready     = rd_gnt;
  assign bus.o_Full         = full;
  assign bus.o_Empty        = empty;
  assign bus.o_Count        = count;
  assign bus.o_Ram_Addr     = wr_gnt ? wr_ptr : rd_ptr;
  assign bus.o_Ram_Wr_DV    = wr_gnt;
  assign bus.o_Ram_Wr_Data  = push_word;
  assign bus.o_Ram_Rd_En    = rd_gnt;
  assign bus.o_Rd_Data      = bus.i_Ram_Rd_Data;
  // RAM read-valid is never reset; a pop answered while reset is asserted is dropped.
  assign bus.o_Rd_DV        = rd_pend && bus.i_Ram_Rd_DV && i_Rst_L;

`ifdef SP_RAM_FIFO_ALMOST_FLAGS_EN
  logic almost_full, almost_empty;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (count_nxt >= CW'(ALMOST_FULL_LEVEL));
      almost_empty <= (count_nxt <= CW'(ALMOST_EMPTY_LEVEL));
    end
  end

  assign bus.o_Almost_Full  = almost_full;
  assign bus.o_Almost_Empty = almost_empty;
`endif

endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Randomized and directed bench for sp_ram_fifo_ctrl (WIDTH=16, DEPTH=8) with a behavioural RAM and queue model.
module tb_sp_ram_fifo_ctrl;
  import sp_ram_fifo_pkg::*;

  localparam int unsigned D = 8;

  logic clk   = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  sp_ram_fifo_ctrl_if #(.WIDTH(16), .DEPTH(D)) bus();

  sp_ram_fifo_ctrl #(
    .WIDTH (16),
    .DEPTH (D)
`ifdef SP_RAM_FIFO_ALMOST_FLAGS_EN
    ,
    .ALMOST_FULL_LEVEL  (6),
    .ALMOST_EMPTY_LEVEL (2)
`endif
  ) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_l),
    .bus     (bus.master)
  );

  // Single-port RAM stand-in: write commits at the edge, read data one cycle later.
  logic [15:0] mem [D];
  logic        ram_rd_dv   = 1'b0;
  logic [15:0] ram_rd_data = '0;
  always @(posedge clk) begin
    if (bus.o_Ram_Wr_DV) mem[bus.o_Ram_Addr] <= bus.o_Ram_Wr_Data;
    ram_rd_dv <= bus.o_Ram_Rd_En;
    if (bus.o_Ram_Rd_En) ram_rd_data <= mem[bus.o_Ram_Addr];
  end
  assign bus.i_Ram_Rd_DV   = ram_rd_dv;
  assign bus.i_Ram_Rd_Data = ram_rd_data;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [15:0] mq[$];
  logic [15:0] got[$];
  int          wp = 0, rp = 0;
  bit          last_wr = 1'b1;
  bit          pend = 1'b0;
  logic [15:0] pend_data = '0;
  bit          chk_en = 1'b0;
  bit          acc_wr, acc_rd;

  always @(negedge clk) begin
    bit we, re, gw, gr;
    if (chk_en) begin
      chk("count", 32'(bus.o_Count), 32'(mq.size()));
      chk("full", 32'(bus.o_Full), 32'(mq.size() == D));
      chk("empty", 32'(bus.o_Empty), 32'(mq.size() == 0));
`ifdef SP_RAM_FIFO_ALMOST_FLAGS_EN
      chk("almost_full", 32'(bus.o_Almost_Full), 32'(mq.size() >= 6));
      chk("almost_empty", 32'(bus.o_Almost_Empty), 32'(mq.size() <= 2));
`endif
      if (!rst_l) begin
        chk("rst_wr_ready", 32'(bus.o_Wr_Ready), 0);
        chk("rst_rd_ready", 32'(bus.o_Rd_Ready), 0);
        chk("rst_rd_dv", 32'(bus.o_Rd_DV), 0);
        chk("rst_ram_wr", 32'(bus.o_Ram_Wr_DV), 0);
        chk("rst_ram_rd", 32'(bus.o_Ram_Rd_En), 0);
        mq.delete();
        wp = 0; rp = 0; last_wr = 1'b1; pend = 1'b0;
      end else begin
        we = bus.i_Wr_DV && (mq.size() < D);
        re = bus.i_Rd_En && (mq.size() > 0);
        if (we && re) begin
          gw = !last_wr;
          last_wr = gw;
        end else begin
          gw = we;
        end
        gr = re && !gw;
        chk("wr_ready", 32'(bus.o_Wr_Ready), 32'(gw));
        chk("rd_ready", 32'(bus.o_Rd_Ready), 32'(gr));
        chk("ram_wr", 32'(bus.o_Ram_Wr_DV), 32'(gw));
        chk("ram_rd", 32'(bus.o_Ram_Rd_En), 32'(gr));
        chk("ram_addr", 32'(bus.o_Ram_Addr), 32'(gw ? wp : rp));
        if (gw) chk("ram_wdata", 32'(bus.o_Ram_Wr_Data), 32'(bus.i_Wr_Data));
        chk("rd_dv", 32'(bus.o_Rd_DV), 32'(pend));
        if (pend) chk("rd_data", 32'(bus.o_Rd_Data), 32'(pend_data));
        if (bus.o_Rd_DV) got.push_back(bus.o_Rd_Data);
        if (gw) begin
          mq.push_back(bus.i_Wr_Data);
          wp = (wp + 1) % D;
        end
        if (gr) begin
          pend_data = mq.pop_front();
          rp = (rp + 1) % D;
        end
        pend = gr;
      end
    end
  end

  task automatic step(input bit wr, input logic [15:0] d, input bit rd);
    bus.i_Wr_DV   = wr;
    bus.i_Wr_Data = d;
    bus.i_Rd_En   = rd;
    @(negedge clk);
    acc_wr = wr && bus.o_Wr_Ready;
    acc_rd = rd && bus.o_Rd_Ready;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] nw;
    bit          prev_w;
    int          pushed, cyc;

    bus.i_Wr_DV = 1'b0; bus.i_Wr_Data = '0; bus.i_Rd_En = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    step(0, 16'h0, 0);
    rst_l = 1'b1;
    chk("reset_empty", 32'(bus.o_Empty), 1);
    chk("reset_full", 32'(bus.o_Full), 0);
    chk("reset_count", 32'(bus.o_Count), 0);
    chk("reset_rd_dv", 32'(bus.o_Rd_DV), 0);
`ifdef SP_RAM_FIFO_ALMOST_FLAGS_EN
    chk("reset_almost_full", 32'(bus.o_Almost_Full), 0);
    chk("reset_almost_empty", 32'(bus.o_Almost_Empty), 1);
`endif

    // 1: fill
    for (int i = 0; i < 8; i++) begin
      step(1, 16'(32'h1000 + i), 0);
      chk("s1_accept", 32'(acc_wr), 1);
      chk("s1_count", 32'(bus.o_Count), 32'(i + 1));
    end
    chk("s1_full", 32'(bus.o_Full), 1);
    step(1, 16'h1008, 0);
    chk("s1_push_when_full", 32'(acc_wr), 0);

    // 2: drain
    got.delete();
    for (int i = 0; i < 8; i++) begin
      step(0, 16'h0, 1);
      chk("s2_accept", 32'(acc_rd), 1);
    end
    chk("s2_empty", 32'(bus.o_Empty), 1);
    step(0, 16'h0, 1);
    chk("s2_pop_when_empty", 32'(acc_rd), 0);
    chk("s2_n_words", 32'(got.size()), 8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk("s2_data", 32'(got[i]), 32'h1000 + 32'(i));

    // 3: contention
    got.delete();
    nw = 16'h2000;
    for (int i = 0; i < 3; i++) begin
      step(1, nw, 0);
      if (acc_wr) nw++;
    end
    step(1, nw, 1);
    chk("s3_first_contention_rd", 32'(acc_rd), 1);
    if (acc_wr) nw++;
    for (int i = 0; i < 2; i++) begin
      step(1, nw, 0);
      if (acc_wr) nw++;
    end
    chk("s3_start_count", 32'(bus.o_Count), 4);
    prev_w = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1, nw, 1);
      if (acc_wr) nw++;
      chk("s3_one_grant", 32'(acc_wr ^ acc_rd), 1);
      if (k == 0) chk("s3_first_wr", 32'(acc_wr), 1);
      else        chk("s3_alternate", 32'(acc_wr), 32'(!prev_w));
      chk("s3_count_band", 32'(bus.o_Count == 4 || bus.o_Count == 5), 1);
      prev_w = acc_wr;
    end
    for (int k = 0; k < 20 && !bus.o_Empty; k++) step(0, 16'h0, 1);
    step(0, 16'h0, 0);
    chk("s3_n_words", 32'(got.size()), 32'(nw - 16'h2000));
    for (int i = 0; i < got.size(); i++)
      chk("s3_order", 32'(got[i]), 32'h2000 + 32'(i));

    // 4: random gaps, wrap twice
    got.delete();
    pushed = 0;
    cyc = 0;
    while ((pushed < 20 || bus.o_Count != 0) && cyc < 2000) begin
      step(pushed < 20 && $urandom_range(0, 2) != 0, 16'(pushed), $urandom_range(0, 2) == 0);
      if (acc_wr) pushed++;
      cyc++;
    end
    step(0, 16'h0, 0);
    chk("s4_budget", 32'(cyc < 2000), 1);
    chk("s4_n_words", 32'(got.size()), 20);
    for (int i = 0; i < 20 && i < got.size(); i++)
      chk("s4_data", 32'(got[i]), 32'(i));

    // 5: reset right after a pop accept
    got.delete();
    step(1, 16'h5A5A, 0);
    step(0, 16'h0, 1);
    chk("s5_pop_accept", 32'(acc_rd), 1);
    rst_l = 1'b0;
    step(0, 16'h0, 0);
    step(0, 16'h0, 0);
    rst_l = 1'b1;
    chk("s5_no_rd_dv", 32'(got.size()), 0);
    chk("s5_empty", 32'(bus.o_Empty), 1);
    chk("s5_count", 32'(bus.o_Count), 0);
    step(1, 16'hBEEF, 0);
    step(0, 16'h0, 1);
    step(0, 16'h0, 0);
    chk("s5_n_words", 32'(got.size()), 1);
    if (got.size() > 0) chk("s5_beef", 32'(got[0]), 32'hBEEF);

`ifdef SP_RAM_FIFO_ALMOST_FLAGS_EN
    // 6: almost flags at levels 6/2
    step(1, 16'h0, 0);
    step(1, 16'h1, 0);
    chk("s6_ae_at_2", 32'(bus.o_Almost_Empty), 1);
    step(1, 16'h2, 0);
    chk("s6_ae_at_3", 32'(bus.o_Almost_Empty), 0);
    step(1, 16'h3, 0);
    step(1, 16'h4, 0);
    chk("s6_af_at_5", 32'(bus.o_Almost_Full), 0);
    step(1, 16'h5, 0);
    chk("s6_af_at_6", 32'(bus.o_Almost_Full), 1);
    step(0, 16'h0, 1);
    chk("s6_af_back_5", 32'(bus.o_Almost_Full), 0);
    chk("s6_count_5", 32'(bus.o_Count), 5);
`endif

    step(0, 16'h0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sp_ram_fifo_ctrl.md
Name: sp_ram_fifo_ctrl

Overview:
FIFO controller that sits directly upstream of the single-port RAM block and turns it into a synchronous FIFO.
- Drives the RAM's shared address, write strobe, write data and read enable.
- Consumes the RAM's one-cycle-latency read data and read-valid.
- Only one RAM access happens per cycle, so the block arbitrates push and pop round-robin.
- Presents valid/ready handshakes to producer and consumer.

Parameters:
WIDTH, 16, data word width; must match the RAM WIDTH
DEPTH, 256, number of entries; must match the RAM DEPTH; any value >= 2 (not restricted to powers of two)
ALMOST_FULL_LEVEL, DEPTH-2, count at or above which o_Almost_Full asserts (optional feature only)
ALMOST_EMPTY_LEVEL, 2, count at or below which o_Almost_Empty asserts (optional feature only)

Ports:
i_Clk  in  1  clock; single clock domain
i_Rst_L  in  1  synchronous reset, active-low
i_Wr_DV  in  1  producer push request
i_Wr_Data  in  WIDTH  push data
o_Wr_Ready  out  1  push accepted this cycle when i_Wr_DV && o_Wr_Ready
i_Rd_En  in  1  consumer pop request
o_Rd_Ready  out  1  pop accepted this cycle when i_Rd_En && o_Rd_Ready
o_Rd_DV  out  1  popped word valid, 1 cycle after pop accept
o_Rd_Data  out  WIDTH  popped word
o_Full  out  1  count == DEPTH
o_Empty  out  1  count == 0
o_Count  out  $clog2(DEPTH+1)  current occupancy
o_Ram_Addr  out  $clog2(DEPTH)  RAM shared address
o_Ram_Wr_DV  out  1  RAM write strobe
o_Ram_Wr_Data  out  WIDTH  RAM write data
o_Ram_Rd_En  out  1  RAM read enable
i_Ram_Rd_DV  in  1  RAM read valid
i_Ram_Rd_Data  in  WIDTH  RAM read data

Behaviour:
- Reset (i_Rst_L=0 at a clock edge) clears:
  - write pointer, read pointer and count to 0
  - round-robin flag to "write last"
  - read-pending flag to 0
- Outputs after reset: o_Empty=1, o_Full=0, o_Count=0, o_Rd_DV=0.
- Eligibility: write is eligible when i_Wr_DV && !o_Full; read is eligible when i_Rd_En && !o_Empty.
- Grant (combinational, one per cycle):
  - If only one requester is eligible, it is granted.
  - If both are eligible, grant the one not granted last. The registered flag updates only when both were eligible.
  - o_Wr_Ready = write granted; o_Rd_Ready = read granted. Both are 0 while i_Rst_L=0.
- RAM drive (combinational):
  - Write grant: o_Ram_Addr = write pointer, o_Ram_Wr_DV=1, o_Ram_Wr_Data = i_Wr_Data.
  - Read grant: o_Ram_Addr = read pointer, o_Ram_Rd_En=1.
  - No grant: address holds the read pointer, both strobes are 0.
- Pointers advance by 1 on their own grant and wrap from DEPTH-1 to 0 explicitly.
- Count: +1 on write grant, -1 on read grant. Never both in one cycle.
- Read path:
  - Read-pending register <= read grant.
  - o_Rd_DV = read-pending && i_Ram_Rd_DV.
  - o_Rd_Data = i_Ram_Rd_Data, passed through.
  - Latency from accepted pop to o_Rd_DV is exactly 1 cycle.
  - The RAM read-valid is not reset, so the pending flag gates it; RAM data outside o_Rd_DV is don't-care.
- Full: push is refused (o_Wr_Ready=0); a pop is still granted the same cycle.
- Empty: pop is refused, even if a push is being accepted in the same cycle.
- A word written at cycle N is poppable from cycle N+1. Data is correct because the RAM write has committed at the N edge.
- Reset mid-operation: a pop accepted in the cycle before reset produces no o_Rd_DV. Contents are logically discarded.

Optional Feature:
Macro SP_RAM_FIFO_ALMOST_FLAGS_EN.
- Defined: adds outputs o_Almost_Full (o_Count >= ALMOST_FULL_LEVEL) and o_Almost_Empty (o_Count <= ALMOST_EMPTY_LEVEL). Both are registered from the next-count value so they change on the same edge as o_Count. Reset values: o_Almost_Full=0, o_Almost_Empty=1.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package sp_ram_fifo_pkg holds:
  - grant encoding constants: GNT_NONE, GNT_WR, GNT_RD
  - pointer/count width helper functions based on $clog2
- Sub-module sp_ram_fifo_arb holds the round-robin two-requester arbiter: eligibility in, one-hot grant out, registered last-grant flag. Pointers, count and read gating stay in the top module.

Test Plan:
All scenarios use WIDTH=16, DEPTH=8, wired to the RAM block.
1. Reset, then push 0x1000..0x1007 with no pops -> o_Count steps 1..8; o_Full=1 after the 8th accept; a 9th push sees o_Wr_Ready=0.
2. From full, pop continuously -> o_Rd_DV exactly 1 cycle after each accept; data 0x1000..0x1007 in order; o_Empty=1 after the 8th; a 9th pop sees o_Rd_Ready=0.
3. With 4 words stored, hold i_Wr_DV=1 and i_Rd_En=1 for 20 cycles -> grants strictly alternate; o_Count oscillates between 4 and 5; pushed and popped data stay in sequence.
4. Push/pop 20 sequential words 0x0000..0x0013 with random request gaps -> pointers wrap 7->0 at least twice; output sequence is intact with no loss or duplication.
5. Assert i_Rst_L=0 the cycle after a pop accept -> o_Rd_DV stays 0; o_Empty=1; o_Count=0; a subsequent push/pop of 0xBEEF returns 0xBEEF.
6. With SP_RAM_FIFO_ALMOST_FLAGS_EN, ALMOST_FULL_LEVEL=6, ALMOST_EMPTY_LEVEL=2 -> o_Almost_Empty drops at count 3; o_Almost_Full rises at count 6 and falls back at 5.
